// File: rtl/axi_route_pkg.sv
// Shared types and helpers for the AXI address-channel routers.
package axi_route_pkg;

    // Largest supported slave count; the default slave takes index MAX_SLAVES.
    localparam int MAX_SLAVES = 16;
    localparam int SLV_IDX_W  = 5;

    // Wide enough for any mapped slave index plus the default slave.
    typedef logic [SLV_IDX_W-1:0] slv_idx_t;

    // One-entry request slice occupancy.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slice_state_e;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // The default slave sits one past the last mapped slave.
    function automatic slv_idx_t default_slv_idx(input int num_slaves);
        return slv_idx_t'(num_slaves);
    endfunction

endpackage

// File: rtl/axi_addr_map_dec.sv
// Combinational base/limit address decoder; the lowest matching index wins,
// and no match yields index NUM_SLAVES (the default slave).
module axi_addr_map_dec
    import axi_route_pkg::*;
#(
    parameter int                            NUM_SLAVES = 6,
    parameter int                            ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_LIMIT  = '0,
    parameter int                            IDX_W      = cnt_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              is_default
);

    // Scan from the highest index down so a lower matching index overrides it.
    always_comb begin
        // NOTE: idx gets a value before the loop so no path leaves it unassigned (no latch).
        idx = IDX_W'(NUM_SLAVES);
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (addr >= SLV_BASE[i*ADDR_W +: ADDR_W] &&
                addr <= SLV_LIMIT[i*ADDR_W +: ADDR_W]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign is_default = (idx == IDX_W'(NUM_SLAVES));

endmodule

// File: rtl/axi_ar_route_ctrl.sv
// AR-channel router for one master port: decodes the address, holds the
// request in a one-entry slice, issues it to a single slave only when that
// cannot interleave R responses, and tracks outstanding bursts.
module axi_ar_route_ctrl
    import axi_route_pkg::*;
#(
    parameter int                            NUM_SLAVES = 6,
    parameter int                            ADDR_W     = 32,
    parameter int                            MAX_OUTST  = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = {NUM_SLAVES{ADDR_W'(0)}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_LIMIT  = {NUM_SLAVES{ADDR_W'(0)}}
) (
    input  logic                               ACLK,
    input  logic                               ARESETn,
    input  logic                               ARVALID_M,
    input  logic [ADDR_W-1:0]                  ARADDR_M,
    output logic                               ARREADY_M,
    output logic [NUM_SLAVES-1:0]              ARVALID_S,
    input  logic [NUM_SLAVES-1:0]              ARREADY_S,
    output logic                               ARVALID_SD,
    input  logic                               ARREADY_SD,
    input  logic                               RVALID_M,
    input  logic                               RREADY_M,
    input  logic                               RLAST_M,
    output logic [$clog2(NUM_SLAVES+1)-1:0]    r_sel,
    output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt,
    output logic                               dec_err
);

    localparam int                SEL_W   = cnt_width(NUM_SLAVES);
    localparam int                CNT_W   = cnt_width(MAX_OUTST);
    localparam logic [SEL_W-1:0]  DEF_SEL = SEL_W'(default_slv_idx(NUM_SLAVES));

    slice_state_e      state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  dec_idx;
    logic              dec_default;
    logic              rdy_en_q;     // holds ARREADY_M low until the first edge after reset
    logic              gate_ok;
    logic              issue_vld;
    logic              slv_rdy;
    logic              issue_hs;
    logic              mst_hs;
    logic              r_done;

    axi_addr_map_dec #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_LIMIT  (SLV_LIMIT),
        .IDX_W      (SEL_W)
    ) u_dec (
        .addr       (ARADDR_M),
        .idx        (dec_idx),
        .is_default (dec_default)
    );

    // Issue gate, one-hot valid fan-out, ready select and handshake strobes.
    always_comb begin
        gate_ok    = ((outst_cnt == '0) || (sel_q == r_sel)) &&
                     (outst_cnt < CNT_W'(MAX_OUTST));
        issue_vld  = (state_q == S_FULL) && gate_ok;
        ARVALID_S  = '0;
        ARVALID_SD = issue_vld && (sel_q == DEF_SEL);
        slv_rdy    = ARREADY_SD;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ARVALID_S[i] = issue_vld;
                slv_rdy      = ARREADY_S[i];
            end
        end
        issue_hs   = issue_vld && slv_rdy;
        // Accept a new request when empty, or in the same cycle the slice drains.
        ARREADY_M  = rdy_en_q && ((state_q == S_EMPTY) || issue_hs);
        mst_hs     = ARVALID_M && ARREADY_M;
        r_done     = RVALID_M && RREADY_M && RLAST_M;
    end

    // Slice next state: load on master handshake, otherwise empty on drain.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (mst_hs) begin
            state_d = S_FULL;
            sel_d   = dec_idx;
        end else if (issue_hs) begin
            state_d = S_EMPTY;
        end
    end

    // Slice register and the post-reset ready enable.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= S_EMPTY;
            sel_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, whatever the statement order.
            state_q  <= state_d;
            sel_q    <= sel_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Outstanding-burst counter, R mux select and decode-error pulse.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            outst_cnt <= '0;
            r_sel     <= '0;
            dec_err   <= 1'b0;
        end else begin
            unique case ({issue_hs, r_done && (outst_cnt != '0)})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase
            if (issue_hs) begin
                r_sel <= sel_q;
            end
            dec_err <= mst_hs && dec_default;
        end
    end

endmodule

// File: tb/tb_axi_ar_route_ctrl.sv
// Testbench for axi_ar_route_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_axi_ar_route_ctrl;

    localparam int NS  = 6;
    localparam int AW  = 32;
    localparam int MO  = 4;

    // Slave 0 and 1 from the directed plan; slave 2 overlaps slave 0 to exercise priority.
    localparam logic [NS*AW-1:0] BASE  = {32'h8000_0000, 32'h4000_0000, 32'h2000_0000,
                                          32'h0000_1000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] LIMIT = {32'h8000_00FF, 32'h4000_FFFF, 32'h2FFF_FFFF,
                                          32'h0000_4FFF, 32'h0001_FFFF, 32'h0000_1FFF};

    logic [31:0] base_a [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_1000,
                                 32'h2000_0000, 32'h4000_0000, 32'h8000_0000};
    logic [31:0] lim_a  [NS] = '{32'h0000_1FFF, 32'h0001_FFFF, 32'h0000_4FFF,
                                 32'h2FFF_FFFF, 32'h4000_FFFF, 32'h8000_00FF};

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          ARVALID_M;
    logic [AW-1:0] ARADDR_M;
    logic          ARREADY_M;
    logic [NS-1:0] ARVALID_S;
    logic [NS-1:0] ARREADY_S;
    logic          ARVALID_SD;
    logic          ARREADY_SD;
    logic          RVALID_M, RREADY_M, RLAST_M;
    logic [2:0]    r_sel;
    logic [2:0]    outst_cnt;
    logic          dec_err;

    int n_vec = 0;
    int n_err = 0;

    axi_ar_route_ctrl #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .MAX_OUTST  (MO),
        .SLV_BASE   (BASE),
        .SLV_LIMIT  (LIMIT)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .ARVALID_M  (ARVALID_M),
        .ARADDR_M   (ARADDR_M),
        .ARREADY_M  (ARREADY_M),
        .ARVALID_S  (ARVALID_S),
        .ARREADY_S  (ARREADY_S),
        .ARVALID_SD (ARVALID_SD),
        .ARREADY_SD (ARREADY_SD),
        .RVALID_M   (RVALID_M),
        .RREADY_M   (RREADY_M),
        .RLAST_M    (RLAST_M),
        .r_sel      (r_sel),
        .outst_cnt  (outst_cnt),
        .dec_err    (dec_err)
    );

    always #5 ACLK = ~ACLK;

    // First region containing the address, else the default slave.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= base_a[i] && a <= lim_a[i]) return i;
        end
        return NS;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled near the falling edge.
    task automatic cyc();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic r_last(input int n);
        RVALID_M = 1'b1; RREADY_M = 1'b1; RLAST_M = 1'b1;
        repeat (n) cyc();
        RVALID_M = 1'b0; RREADY_M = 1'b0; RLAST_M = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; ARVALID_M = 1'b0; ARADDR_M = '0;
        ARREADY_S = '1; ARREADY_SD = 1'b1;
        RVALID_M = 1'b0; RREADY_M = 1'b0; RLAST_M = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        n_vec++; if (ARREADY_M !== 1'b0) begin n_err++; $display("FAIL rst_arready got %b exp 0", ARREADY_M); end
        n_vec++; if ({ARVALID_S, ARVALID_SD} !== 7'b0) begin n_err++; $display("FAIL rst_arvalid got %b exp 0", {ARVALID_S, ARVALID_SD}); end
        n_vec++; if ({r_sel, outst_cnt, dec_err} !== 7'b0) begin n_err++; $display("FAIL rst_regs got %b exp 0", {r_sel, outst_cnt, dec_err}); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        cyc();
        n_vec++; if (ARREADY_M !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", ARREADY_M); end
    endtask

    task automatic test_single();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0100;
        cyc();
        ARVALID_M = 1'b0; #1;
        n_vec++; if (ARVALID_S !== 6'b000001) begin n_err++; $display("FAIL single_valid got %b exp 000001", ARVALID_S); end
        cyc();
        n_vec++; if (r_sel !== 3'd0 || outst_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt got sel=%0d cnt=%0d exp 0/1", r_sel, outst_cnt); end
        n_vec++; if (ARVALID_S !== 6'b0) begin n_err++; $display("FAIL single_drop got %b exp 0", ARVALID_S); end
        r_last(1);
        n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL single_drain got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_back_to_back();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0001_0000;
        cyc();
        ARADDR_M = 32'h0001_0004; #1;
        n_vec++; if (ARREADY_M !== 1'b1 || ARVALID_S !== 6'b000010) begin n_err++; $display("FAIL b2b_pass got rdy=%b vld=%b exp 1/000010", ARREADY_M, ARVALID_S); end
        cyc();
        ARVALID_M = 1'b0; #1;
        n_vec++; if (ARVALID_S !== 6'b000010 || outst_cnt !== 3'd1 || r_sel !== 3'd1) begin n_err++; $display("FAIL b2b_second got vld=%b cnt=%0d sel=%0d exp 000010/1/1", ARVALID_S, outst_cnt, r_sel); end
        cyc();
        n_vec++; if (outst_cnt !== 3'd2 || ARVALID_S !== 6'b0) begin n_err++; $display("FAIL b2b_cnt got cnt=%0d vld=%b exp 2/0", outst_cnt, ARVALID_S); end
        r_last(2);
        n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL b2b_drain got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_no_interleave();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0040;
        cyc();
        ARVALID_M = 1'b0;
        cyc();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0001_0100;
        cyc();
        ARVALID_M = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (ARVALID_S !== 6'b0 || ARREADY_M !== 1'b0) begin n_err++; $display("FAIL intlv_hold got vld=%b rdy=%b exp 0/0", ARVALID_S, ARREADY_M); end
            cyc();
        end
        RVALID_M = 1'b1; RREADY_M = 1'b1; RLAST_M = 1'b1; #1;
        n_vec++; if (ARVALID_S !== 6'b0) begin n_err++; $display("FAIL intlv_same_cycle got %b exp 0", ARVALID_S); end
        cyc();
        RVALID_M = 1'b0; RREADY_M = 1'b0; RLAST_M = 1'b0; #1;
        n_vec++; if (ARVALID_S !== 6'b000010 || outst_cnt !== 3'd0) begin n_err++; $display("FAIL intlv_issue got vld=%b cnt=%0d exp 000010/0", ARVALID_S, outst_cnt); end
        cyc();
        n_vec++; if (r_sel !== 3'd1 || outst_cnt !== 3'd1) begin n_err++; $display("FAIL intlv_rsel got sel=%0d cnt=%0d exp 1/1", r_sel, outst_cnt); end
        r_last(1);
    endtask

    task automatic test_unmapped();
        ARVALID_M = 1'b1; ARADDR_M = 32'h3000_0000;
        cyc();
        ARVALID_M = 1'b0; #1;
        n_vec++; if (ARVALID_SD !== 1'b1 || ARVALID_S !== 6'b0) begin n_err++; $display("FAIL unmap_valid got sd=%b s=%b exp 1/0", ARVALID_SD, ARVALID_S); end
        n_vec++; if (dec_err !== 1'b1) begin n_err++; $display("FAIL unmap_err got %b exp 1", dec_err); end
        cyc();
        n_vec++; if (dec_err !== 1'b0 || r_sel !== 3'd6 || outst_cnt !== 3'd1) begin n_err++; $display("FAIL unmap_after got err=%b sel=%0d cnt=%0d exp 0/6/1", dec_err, r_sel, outst_cnt); end
        r_last(1);
        n_vec++; if (r_sel !== 3'd6 || outst_cnt !== 3'd0) begin n_err++; $display("FAIL unmap_hold got sel=%0d cnt=%0d exp 6/0", r_sel, outst_cnt); end
    endtask

    task automatic test_max_outst();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0200;
        repeat (5) cyc();
        ARVALID_M = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++; if (outst_cnt !== 3'd4 || ARVALID_S !== 6'b0 || ARREADY_M !== 1'b0) begin n_err++; $display("FAIL max_block got cnt=%0d vld=%b rdy=%b exp 4/0/0", outst_cnt, ARVALID_S, ARREADY_M); end
            cyc();
        end
        RVALID_M = 1'b1; RREADY_M = 1'b1; RLAST_M = 1'b1; #1;
        n_vec++; if (ARVALID_S !== 6'b0) begin n_err++; $display("FAIL max_same_cycle got %b exp 0", ARVALID_S); end
        cyc();
        RVALID_M = 1'b0; RREADY_M = 1'b0; RLAST_M = 1'b0; #1;
        n_vec++; if (ARVALID_S !== 6'b000001) begin n_err++; $display("FAIL max_issue got %b exp 000001", ARVALID_S); end
        cyc();
        n_vec++; if (outst_cnt !== 3'd4) begin n_err++; $display("FAIL max_refill got %0d exp 4", outst_cnt); end
        r_last(4);
        n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL max_drain got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_reset_mid();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0300;
        cyc();
        ARVALID_M = 1'b0;
        cyc();
        ARREADY_S = '0;
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0304;
        cyc();
        ARVALID_M = 1'b0; #1;
        n_vec++; if (ARVALID_S !== 6'b000001 || outst_cnt !== 3'd1) begin n_err++; $display("FAIL mid_pre got vld=%b cnt=%0d exp 000001/1", ARVALID_S, outst_cnt); end
        #2 ARESETn = 1'b0;
        #1;
        n_vec++; if ({ARVALID_S, ARVALID_SD} !== 7'b0 || outst_cnt !== 3'd0 || ARREADY_M !== 1'b0) begin n_err++; $display("FAIL mid_async got vld=%b cnt=%0d rdy=%b exp 0/0/0", {ARVALID_S, ARVALID_SD}, outst_cnt, ARREADY_M); end
        @(negedge ACLK);
        ARESETn = 1'b1; ARREADY_S = '1;
        cyc();
        ARVALID_M = 1'b1; ARADDR_M = 32'h0001_0000;
        cyc();
        ARVALID_M = 1'b0; #1;
        n_vec++; if (ARVALID_S !== 6'b000010) begin n_err++; $display("FAIL mid_post got %b exp 000010", ARVALID_S); end
        cyc();
        n_vec++; if (r_sel !== 3'd1 || outst_cnt !== 3'd1) begin n_err++; $display("FAIL mid_post_cnt got sel=%0d cnt=%0d exp 1/1", r_sel, outst_cnt); end
        r_last(1);
    endtask

    task automatic test_random();
        bit            m_rdy, m_full, m_derr, gate, rdy, iss, exp_ar, mhs, rd;
        int            m_sel, m_cnt, m_rsel, d, r, k;
        logic [NS-1:0] exp_s;
        logic          exp_sd;

        @(negedge ACLK);
        ARESETn = 1'b0; ARVALID_M = 1'b0;
        RVALID_M = 1'b0; RREADY_M = 1'b0; RLAST_M = 1'b0;
        #1 ARESETn = 1'b1;
        m_rdy = 0; m_full = 0; m_derr = 0; m_sel = 0; m_cnt = 0; m_rsel = 0;

        for (int cycle = 0; cycle < 600; cycle++) begin
            ARVALID_M  = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            k = $urandom_range(0, NS - 1);
            if (r < 6) begin
                case ($urandom_range(0, 4))
                    0:       ARADDR_M = base_a[k];
                    1:       ARADDR_M = lim_a[k];
                    2:       ARADDR_M = lim_a[k] + 1;
                    3:       ARADDR_M = base_a[k] - 1;
                    default: ARADDR_M = base_a[k] + ($urandom % (lim_a[k] - base_a[k] + 1));
                endcase
            end else begin
                ARADDR_M = $urandom;
            end
            for (int i = 0; i < NS; i++) ARREADY_S[i] = ($urandom_range(0, 9) < 7);
            ARREADY_SD = ($urandom_range(0, 9) < 7);
            RVALID_M   = $urandom_range(0, 1);
            RREADY_M   = $urandom_range(0, 1);
            RLAST_M    = (m_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;

            // Expected behaviour from the routing rules, at transaction level.
            gate   = m_full && (m_cnt == 0 || m_sel == m_rsel) && (m_cnt < MO);
            exp_s  = '0;
            exp_sd = 1'b0;
            if (gate) begin
                if (m_sel == NS) exp_sd = 1'b1;
                else exp_s[m_sel] = 1'b1;
            end
            rdy    = (m_sel == NS) ? ARREADY_SD : ARREADY_S[m_sel];
            iss    = gate && rdy;
            exp_ar = m_rdy && (!m_full || iss);
            mhs    = ARVALID_M && exp_ar;
            rd     = RVALID_M && RREADY_M && RLAST_M;
            d      = ref_decode(ARADDR_M);

            n_vec++; if (ARREADY_M !== exp_ar) begin n_err++; $display("FAIL rnd_arready cyc %0d got %b exp %b", cycle, ARREADY_M, exp_ar); end
            n_vec++; if (ARVALID_S !== exp_s) begin n_err++; $display("FAIL rnd_arvalid_s cyc %0d got %b exp %b", cycle, ARVALID_S, exp_s); end
            n_vec++; if (ARVALID_SD !== exp_sd) begin n_err++; $display("FAIL rnd_arvalid_sd cyc %0d got %b exp %b", cycle, ARVALID_SD, exp_sd); end
            n_vec++; if (r_sel !== 3'(m_rsel)) begin n_err++; $display("FAIL rnd_r_sel cyc %0d got %0d exp %0d", cycle, r_sel, m_rsel); end
            n_vec++; if (outst_cnt !== 3'(m_cnt)) begin n_err++; $display("FAIL rnd_outst cyc %0d got %0d exp %0d", cycle, outst_cnt, m_cnt); end
            n_vec++; if (dec_err !== m_derr) begin n_err++; $display("FAIL rnd_dec_err cyc %0d got %b exp %b", cycle, dec_err, m_derr); end

            @(posedge ACLK);
            m_cnt  = m_cnt + (iss ? 1 : 0) - (rd ? 1 : 0);
            if (iss) m_rsel = m_sel;
            m_derr = mhs && (d == NS);
            if (mhs) begin
                m_full = 1;
                m_sel  = d;
            end else if (iss) begin
                m_full = 0;
            end
            m_rdy = 1;
            @(negedge ACLK);
        end
        ARVALID_M = 1'b0;
        RVALID_M = 1'b0; RREADY_M = 1'b0; RLAST_M = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_interleave();
        test_unmapped();
        test_max_outst();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
